// File: rtl/sram_port_arbiter_if.sv
// sram-like port bundle: req/addr_ok address phase, in-order data_ok.
// The master side drives the request fields; the slave side answers.
interface sram_port_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one sram-like slave port between the inst and data requesters.
// An owner FIFO remembers who issued each in-order outstanding access.
module sram_port_arbiter #(
    parameter int OUTSTANDING     = 4,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_port_arbiter_if.slave    inst,
    sram_port_arbiter_if.slave    data,
    sram_port_arbiter_if.master   s,
    output logic                  err_unexp
);
    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);

    logic [OUTSTANDING-1:0] r_owner;
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [CW-1:0]          r_cnt;
    logic                   r_lock;
    logic                   r_lock_own;
    logic [SW-1:0]          r_streak;
    logic                   r_err;

    logic w_gnt_d;
    logic w_sel_req;
    logic w_full;
    logic w_empty;
    logic w_s_req;
    logic w_hs;
    logic w_hs_i;
    logic w_hs_d;
    logic w_pop;
    logic w_head;
    logic w_streak_max;

    assign w_full       = (r_cnt == CW'(OUTSTANDING));
    assign w_empty      = (r_cnt == '0);
    assign w_streak_max = (r_streak == SW'(MAX_DATA_STREAK));

    // Grant: a stalled owner keeps the port, else data first unless inst starves.
    always_comb begin
        w_gnt_d = 1'b0;
        if (r_lock)
            w_gnt_d = r_lock_own;
        else if (inst.req && w_streak_max)
            w_gnt_d = 1'b0;
        else
            w_gnt_d = data.req;
    end

    assign w_sel_req = w_gnt_d ? data.req : inst.req;
    assign w_s_req   = rst_n & w_sel_req & ~w_full;
    assign w_hs      = w_s_req & s.addr_ok;
    assign w_hs_i    = w_hs & ~w_gnt_d;
    assign w_hs_d    = w_hs & w_gnt_d;
    assign w_pop     = rst_n & s.data_ok & ~w_empty;
    assign w_head    = r_owner[r_rptr];

    assign s.req   = w_s_req;
    assign s.wr    = rst_n & (w_gnt_d ? data.wr : inst.wr);
    assign s.size  = {2{rst_n}} & (w_gnt_d ? data.size : inst.size);
    assign s.wstrb = {4{rst_n}} & (w_gnt_d ? data.wstrb : inst.wstrb);
    assign s.addr  = {32{rst_n}} & (w_gnt_d ? data.addr : inst.addr);
    assign s.wdata = {32{rst_n}} & (w_gnt_d ? data.wdata : inst.wdata);

    assign inst.addr_ok = w_hs_i;
    assign data.addr_ok = w_hs_d;
    assign inst.data_ok = w_pop & ~w_head;
    assign data.data_ok = w_pop & w_head;
    assign inst.rdata   = {32{rst_n}} & s.rdata;
    assign data.rdata   = {32{rst_n}} & s.rdata;
    assign err_unexp    = rst_n & r_err;

    // Owner FIFO: push on accepted address, pop on each in-order response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_hs) begin
                r_owner[r_wptr] <= w_gnt_d;
                r_wptr          <= r_wptr + PW'(1);
            end
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            if (w_hs && !w_pop)
                r_cnt <= r_cnt + CW'(1);
            else if (!w_hs && w_pop)
                r_cnt <= r_cnt - CW'(1);
        end
    end

    // Lock holds the grant on a stalled owner until its address is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lock     <= 1'b0;
            r_lock_own <= 1'b0;
        end else if (w_s_req && !s.addr_ok) begin
            r_lock     <= 1'b1;
            r_lock_own <= w_gnt_d;
        end else if (w_hs || !w_sel_req) begin
            r_lock     <= 1'b0;
        end
    end

    // Count data grants taken while inst waits; saturate at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_streak <= '0;
        else if (!inst.req || w_hs_i)
            r_streak <= '0;
        else if (w_hs_d && !w_streak_max)
            r_streak <= r_streak + SW'(1);
    end

    // Sticky flag for a response that has no outstanding owner.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (s.data_ok && w_empty)
            r_err <= 1'b1;
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus a randomized run
// against a queue-based model of owners, streaks and the fill limit.
module tb_sram_port_arbiter;
    localparam int OUT = 4;
    localparam int MAXS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err;
    int checks = 0;
    int errors = 0;

    sram_port_arbiter_if ii ();
    sram_port_arbiter_if di ();
    sram_port_arbiter_if si ();

    sram_port_arbiter #(.OUTSTANDING(OUT), .MAX_DATA_STREAK(MAXS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inst      (ii),
        .data      (di),
        .s         (si),
        .err_unexp (err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ii.req = 0; ii.wr = 0; ii.size = 2; ii.wstrb = 0;
        ii.addr = 0; ii.wdata = 0;
        di.req = 0; di.wr = 0; di.size = 2; di.wstrb = 0;
        di.addr = 0; di.wdata = 0;
        si.addr_ok = 0; si.data_ok = 0; si.rdata = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        ii.req = 1; ii.addr = 32'h1234_5678;
        si.addr_ok = 1; si.data_ok = 1;
        cyc(); cyc();
        checks++;
        if (si.req !== 1'b0) begin
            errors++; $display("FAIL reset_s_req: got %b need 0", si.req);
        end
        checks++;
        if (ii.addr_ok !== 1'b0 || ii.data_ok !== 1'b0) begin
            errors++;
            $display("FAIL reset_ok: got %b%b need 00", ii.addr_ok, ii.data_ok);
        end
        checks++;
        if (err !== 1'b0 || si.addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_err_addr: got %b %h need 0 0", err, si.addr);
        end
        idle();
        rst_n = 1;
        cyc();
    endtask

    task automatic test_single_inst();
        ii.req = 1; ii.addr = 32'hBFC0_0000; si.addr_ok = 1;
        #1;
        checks++;
        if (ii.addr_ok !== 1'b1 || si.addr !== 32'hBFC0_0000) begin
            errors++;
            $display("FAIL single_addr: got %b %h need 1 bfc00000", ii.addr_ok, si.addr);
        end
        cyc(); idle();
        cyc();
        si.data_ok = 1; si.rdata = 32'h3C1D_0001;
        #1;
        checks++;
        if (ii.data_ok !== 1'b1 || ii.rdata !== 32'h3C1D_0001) begin
            errors++;
            $display("FAIL single_data: got %b %h need 1 3c1d0001", ii.data_ok, ii.rdata);
        end
        checks++;
        if (di.data_ok !== 1'b0) begin
            errors++; $display("FAIL single_no_data: got %b need 0", di.data_ok);
        end
        cyc(); idle();
    endtask

    task automatic test_simultaneous();
        ii.req = 1; ii.addr = 32'h0000_1000;
        di.req = 1; di.addr = 32'h8000_2000;
        si.addr_ok = 1;
        #1;
        checks++;
        if (di.addr_ok !== 1'b1 || ii.addr_ok !== 1'b0 || si.addr !== 32'h8000_2000) begin
            errors++;
            $display("FAIL simul_first: got d%b i%b %h need d1 i0", di.addr_ok, ii.addr_ok, si.addr);
        end
        cyc(); di.req = 0;
        #1;
        checks++;
        if (ii.addr_ok !== 1'b1 || si.addr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL simul_second: got %b %h need 1 00001000", ii.addr_ok, si.addr);
        end
        cyc(); idle();
        si.data_ok = 1; si.rdata = 32'hAAAA_0001;
        #1;
        checks++;
        if (di.data_ok !== 1'b1 || ii.data_ok !== 1'b0 || di.rdata !== 32'hAAAA_0001) begin
            errors++;
            $display("FAIL simul_resp1: got d%b i%b need d1 i0", di.data_ok, ii.data_ok);
        end
        cyc();
        si.rdata = 32'hBBBB_0002;
        #1;
        checks++;
        if (ii.data_ok !== 1'b1 || di.data_ok !== 1'b0 || ii.rdata !== 32'hBBBB_0002) begin
            errors++;
            $display("FAIL simul_resp2: got i%b d%b need i1 d0", ii.data_ok, di.data_ok);
        end
        cyc(); idle();
    endtask

    task automatic test_lock();
        di.req = 1; di.addr = 32'hA000_0010;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin ii.req = 1; ii.addr = 32'hBFC0_0100; end
            si.addr_ok = (k >= 3);
            #1;
            if (k < 4) begin
                checks++;
                if (si.addr !== 32'hA000_0010 || si.req !== 1'b1) begin
                    errors++;
                    $display("FAIL lock_hold%0d: got %h need a0000010", k, si.addr);
                end
                checks++;
                if (di.addr_ok !== (k == 3) || ii.addr_ok !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_ok%0d: got d%b i%b", k, di.addr_ok, ii.addr_ok);
                end
            end else begin
                checks++;
                if (ii.addr_ok !== 1'b1 || si.addr !== 32'hBFC0_0100) begin
                    errors++;
                    $display("FAIL lock_inst: got %b %h need 1 bfc00100", ii.addr_ok, si.addr);
                end
            end
            cyc();
            if (k == 3) di.req = 0;
        end
        idle();
        si.data_ok = 1;
        cyc(); cyc();
        idle();
    endtask

    task automatic test_starvation();
        logic exp_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        int oc = 0;
        ii.req = 1; di.req = 1; si.addr_ok = 1;
        for (int k = 0; k < 10; k++) begin
            si.data_ok = (oc > 0);
            #1;
            checks++;
            if (di.addr_ok !== exp_d[k] || ii.addr_ok !== !exp_d[k]) begin
                errors++;
                $display("FAIL starve_%0d: got d%b i%b need d%b", k, di.addr_ok, ii.addr_ok, exp_d[k]);
            end
            if (si.data_ok) oc--;
            if (si.req && si.addr_ok) oc++;
            cyc();
            ii.addr = ii.addr + 4; di.addr = di.addr + 4;
        end
        idle();
        for (int k = 0; k < 4 && oc > 0; k++) begin
            si.data_ok = 1; oc--; cyc();
        end
        idle();
    endtask

    task automatic test_full();
        di.req = 1; si.addr_ok = 1;
        for (int k = 0; k < 8; k++) begin
            di.addr = 32'h100 + k;
            si.data_ok = (k == 6);
            #1;
            if (k < 4) begin
                checks++;
                if (di.addr_ok !== 1'b1) begin
                    errors++; $display("FAIL full_fill%0d: got %b need 1", k, di.addr_ok);
                end
            end else if (k < 7) begin
                checks++;
                if (si.req !== 1'b0 || di.addr_ok !== 1'b0) begin
                    errors++; $display("FAIL full_block%0d: got %b need 0", k, si.req);
                end
            end else begin
                checks++;
                if (si.req !== 1'b1 || di.addr_ok !== 1'b1) begin
                    errors++; $display("FAIL full_resume: got %b need 1", si.req);
                end
            end
            cyc();
            if (k < 4) di.addr = 32'h100 + k + 1;
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            si.data_ok = 1;
            #1;
            checks++;
            if (di.data_ok !== 1'b1 || ii.data_ok !== 1'b0) begin
                errors++; $display("FAIL full_drain%0d: got %b need 1", k, di.data_ok);
            end
            cyc();
        end
        idle();
    endtask

    task automatic test_unexpected();
        si.data_ok = 1;
        #1;
        checks++;
        if (ii.data_ok !== 1'b0 || di.data_ok !== 1'b0) begin
            errors++; $display("FAIL unexp_route: got %b%b need 00", ii.data_ok, di.data_ok);
        end
        cyc(); idle();
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL unexp_set: got %b need 1", err);
        end
        cyc(); cyc();
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL unexp_sticky: got %b need 1", err);
        end
        rst_n = 0; cyc(); rst_n = 1;
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL unexp_clear: got %b need 0", err);
        end
        ii.req = 1; si.addr_ok = 1; si.data_ok = 1;
        #1;
        checks++;
        if (ii.addr_ok !== 1'b1 || ii.data_ok !== 1'b0) begin
            errors++; $display("FAIL same_cycle: got a%b d%b need a1 d0", ii.addr_ok, ii.data_ok);
        end
        cyc(); idle();
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL same_cycle_err: got %b need 1", err);
        end
        rst_n = 0; cyc(); rst_n = 1;
        di.req = 1; si.addr_ok = 1;
        cyc(); idle();
        rst_n = 0; cyc(); rst_n = 1;
        si.data_ok = 1;
        #1;
        checks++;
        if (di.data_ok !== 1'b0) begin
            errors++; $display("FAIL midreset_route: got %b need 0", di.data_ok);
        end
        cyc(); idle();
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL midreset_err: got %b need 1", err);
        end
        rst_n = 0; cyc(); rst_n = 1;
    endtask

    task automatic test_random();
        int q[$];
        int stm = 0;
        logic prev_stall = 0;
        logic [31:0] prev_addr = 0;
        logic ihs, dhs, full, ei, ed;
        logic [31:0] rd;
        for (int c = 0; c < 3200; c++) begin
            if (c < 3000 && !ii.req && $urandom_range(1, 0) == 1) begin
                ii.req = 1; ii.wr = 1'($urandom); ii.size = 2'($urandom_range(2, 0));
                ii.wstrb = 4'($urandom); ii.addr = $urandom; ii.wdata = $urandom;
            end
            if (c < 3000 && !di.req && $urandom_range(3, 0) != 0) begin
                di.req = 1; di.wr = 1'($urandom); di.size = 2'($urandom_range(2, 0));
                di.wstrb = 4'($urandom); di.addr = $urandom; di.wdata = $urandom;
            end
            si.addr_ok = (c >= 3000) || ($urandom_range(3, 0) != 0);
            si.data_ok = (q.size() > 0) && ($urandom_range(1, 0) == 1);
            rd = $urandom;
            si.rdata = rd;
            #1;
            full = (q.size() == OUT);
            checks++;
            if (si.req !== ((ii.req || di.req) && !full)) begin
                errors++;
                $display("FAIL rnd_sreq c%0d: got %b full %b", c, si.req, full);
            end
            checks++;
            if ((ii.addr_ok | di.addr_ok) !== (si.req & si.addr_ok) || (ii.addr_ok & di.addr_ok)) begin
                errors++;
                $display("FAIL rnd_hs c%0d: got i%b d%b", c, ii.addr_ok, di.addr_ok);
            end
            if (ii.addr_ok) begin
                checks++;
                if ({si.wr, si.size, si.wstrb, si.addr, si.wdata} !==
                    {ii.wr, ii.size, ii.wstrb, ii.addr, ii.wdata}) begin
                    errors++; $display("FAIL rnd_imux c%0d: got %h need %h", c, si.addr, ii.addr);
                end
            end
            if (di.addr_ok) begin
                checks++;
                if ({si.wr, si.size, si.wstrb, si.addr, si.wdata} !==
                    {di.wr, di.size, di.wstrb, di.addr, di.wdata}) begin
                    errors++; $display("FAIL rnd_dmux c%0d: got %h need %h", c, si.addr, di.addr);
                end
                checks++;
                if (ii.req && stm == MAXS) begin
                    errors++; $display("FAIL rnd_starve c%0d: got %0d need <%0d", c, stm + 1, MAXS + 1);
                end
            end
            if (prev_stall) begin
                checks++;
                if (si.req !== 1'b1 || si.addr !== prev_addr) begin
                    errors++; $display("FAIL rnd_stable c%0d: got %h need %h", c, si.addr, prev_addr);
                end
            end
            ei = si.data_ok && q.size() > 0 && q[0] == 0;
            ed = si.data_ok && q.size() > 0 && q[0] == 1;
            checks++;
            if (ii.data_ok !== ei || di.data_ok !== ed) begin
                errors++;
                $display("FAIL rnd_route c%0d: got i%b d%b need i%b d%b", c, ii.data_ok, di.data_ok, ei, ed);
            end
            if (ei || ed) begin
                checks++;
                if ((ei ? ii.rdata : di.rdata) !== rd) begin
                    errors++; $display("FAIL rnd_rdata c%0d: got %h need %h", c, ei ? ii.rdata : di.rdata, rd);
                end
            end
            checks++;
            if (err !== 1'b0) begin
                errors++; $display("FAIL rnd_err c%0d: got %b need 0", c, err);
            end
            if (si.data_ok && q.size() > 0) void'(q.pop_front());
            ihs = ii.addr_ok; dhs = di.addr_ok;
            if (ihs) q.push_back(0);
            if (dhs) q.push_back(1);
            if (!ii.req || ihs) stm = 0;
            else if (dhs) stm++;
            prev_stall = si.req && !si.addr_ok;
            prev_addr = si.addr;
            cyc();
            if (ihs) ii.req = 0;
            if (dhs) di.req = 0;
        end
        checks++;
        if (q.size() != 0 || ii.req || di.req) begin
            errors++; $display("FAIL rnd_drain: got %0d pending need 0", q.size());
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_inst();
        test_simultaneous();
        test_lock();
        test_starvation();
        test_full();
        test_unexpected();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one sram-like slave port (req/addr_ok/data_ok protocol) between the fetch requester (inst) and the memory-stage requester (data).
- Sits between the pipeline's inst/data sram-like master ports and the single bridge to the memory system.
- Arbitrates the address phase and tracks in-order outstanding transactions in an owner FIFO.
- Routes each data_ok and rdata back to the requester that issued the transaction.

Parameters:
- OUTSTANDING, 4: maximum accepted but not yet answered transactions (owner FIFO depth, power of 2, at least 2).
- MAX_DATA_STREAK, 4: consecutive data grants allowed while inst is waiting before inst is forced a grant.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- inst_req / data_req  in  1  request valid
- inst_wr / data_wr  in  1  1 = write
- inst_size / data_size  in  2  0 = byte, 1 = half, 2 = word
- inst_wstrb / data_wstrb  in  4  byte write strobes
- inst_addr / data_addr  in  32  physical byte address
- inst_wdata / data_wdata  in  32  write data
- inst_addr_ok / data_addr_ok  out  1  address phase accepted
- inst_data_ok / data_data_ok  out  1  response for oldest transaction of that requester
- inst_rdata / data_rdata  out  32  read data, valid with the matching data_ok
- s_req  out  1  to slave: request valid
- s_wr  out  1  to slave: 1 = write
- s_size  out  2  to slave: access size
- s_wstrb  out  4  to slave: byte write strobes
- s_addr  out  32  to slave: address
- s_wdata  out  32  to slave: write data
- s_addr_ok  in  1  from slave: address phase accepted
- s_data_ok  in  1  from slave: response valid, in order
- s_rdata  in  32  from slave: read data
- err_unexp  out  1  sticky: s_data_ok seen with owner FIFO empty

Behaviour:
- **Protocol.**
  - A master holds req and all fields stable until it sees addr_ok.
  - The slave returns responses strictly in acceptance order.
- **Address phase is combinational.**
  - s_req = granted requester's req, and not fifo_full.
  - s_* fields are muxed from the granted requester.
  - x_addr_ok = granted(x) & s_addr_ok & s_req.
- **Grant selection when unlocked.**
  - data wins over inst.
  - Exception: if inst_req is high and streak == MAX_DATA_STREAK, inst wins.
- **Grant lock.**
  - When s_req is high and s_addr_ok is low, register lock = 1 and lock_owner = the current grant.
  - Next cycle the grant is lock_owner regardless of priority; this keeps s_* stable until addr_ok.
  - lock clears on the handshake cycle.
- **Streak counter (0..MAX_DATA_STREAK, saturating).**
  - Increments on a data handshake while inst_req is high.
  - Clears on any inst handshake, or when inst_req is low.
- **Owner FIFO, OUTSTANDING entries of 1 bit (0 = inst, 1 = data).**
  - Push on the s_req & s_addr_ok handshake.
  - Pop on s_data_ok.
  - Pointers wrap modulo OUTSTANDING; count width is log2(OUTSTANDING)+1.
- **Full.** No new s_req while count == OUTSTANDING, even if a pop occurs in the same cycle; the grant is issued the next cycle.
- **Push and pop in the same non-full cycle.** count is unchanged, both pointers advance.
- **Response routing.**
  - x_data_ok = s_data_ok & fifo_not_empty & (head owner == x).
  - s_rdata drives both rdata outputs.
  - Writes also get data_ok.
- **Unexpected response.** s_data_ok with the FIFO empty sets err_unexp (sticky until reset); nothing is popped and no data_ok is asserted.
- **Zero-latency response.** A response may arrive in the cycle after acceptance at the earliest.
  - An entry pushed this cycle is not visible at head until the next cycle.
  - s_data_ok in the same cycle as the push of the only entry counts as unexpected.
- **Reset (rst_n low at clk edge).**
  - FIFO empty, lock = 0, streak = 0, err_unexp = 0.
  - All outputs are 0 while rst_n is low: s_req forced 0, addr_ok and data_ok forced 0.
- **Reset mid-operation.** In-flight transactions are forgotten; responses arriving after reset raise err_unexp.

Test Plan:
- **Single inst read.** inst_req, addr 0xBFC00000, s_addr_ok same cycle, s_data_ok 2 cycles later with rdata 0x3C1D0001.
  - Required: inst_addr_ok in cycle 0.
  - Required: inst_data_ok with inst_rdata 0x3C1D0001 in cycle 2; data_data_ok stays 0.
- **Simultaneous requests, no stall.** Both req high.
  - Required: data granted first.
  - Required: inst granted next cycle.
  - Required: FIFO order data, inst; responses routed in that order.
- **Lock.** data_req with s_addr_ok held low 3 cycles; inst_req rises in cycle 1.
  - Required: s_addr stays equal to data_addr all 4 cycles.
  - Required: data_addr_ok in cycle 3, inst granted in cycle 4.
- **Starvation.** data_req and inst_req continuously high, slave always ready, MAX_DATA_STREAK = 4.
  - Required grant pattern: D, D, D, D, I, D, D, D, D, I.
- **Full.** OUTSTANDING = 4, 4 accepted with no response.
  - Required: s_req low.
  - Required: s_data_ok in cycle N gives s_req high in cycle N+1.
- **Unexpected response and reset.** Pulse s_data_ok with the FIFO empty.
  - Required: err_unexp = 1 and stays 1.
  - Required: rst_n low for 1 cycle gives err_unexp = 0.
